// File: rtl/ps2_key_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : ps2_key_rx
// Brief    : PS/2 keyboard receiver: pin sync, 11-bit frame deserialiser,
//            E0/F0 prefix decode and flap-key strike. Optional frame watchdog
//            is built when PS2_WATCHDOG_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_key_rx #(
    parameter int         SYNC_STAGES    = 2,
    parameter int         TIMEOUT_CYCLES = 100000,
    parameter logic [7:0] FLAP_CODE      = 8'h29
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_ps2,
    input  logic       data_ps2,
    output logic [7:0] scan_code,
    output logic       scan_valid,
    output logic       is_break,
    output logic       is_extended,
    output logic       frame_err,
    output logic       key_held,
    output logic       flap
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_data   = 2'd1;
    localparam logic [1:0] c_st_parity = 2'd2;
    localparam logic [1:0] c_st_stop   = 2'd3;

    localparam logic [7:0] c_pfx_ext = 8'hE0;
    localparam logic [7:0] c_pfx_brk = 8'hF0;

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic                   r_clk_hist;
    logic                   w_clk_s;
    logic                   w_data_s;
    logic                   w_fall;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       w_frame_end;
    logic       w_wd_expired;

    logic [7:0] r_shift;
    logic [2:0] r_bit_cnt;
    logic       r_parity;

    logic       r_chk_vld;
    logic       r_chk_stop;
    logic       r_dec_vld;
    logic       r_dec_ok;
    logic [7:0] r_dec_byte;

    logic [7:0] r_scan_code;
    logic       r_scan_valid;
    logic       r_is_break;
    logic       r_is_extended;
    logic       r_frame_err;
    logic       r_key_held;
    logic       r_flap;
    logic       r_ext_pending;
    logic       r_brk_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_sync  <= '0;
            r_data_sync <= '0;
            r_clk_hist  <= 1'b0;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], clk_ps2};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], data_ps2};
            r_clk_hist  <= r_clk_sync[SYNC_STAGES-1];
        end
    end

    assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
    assign w_data_s = r_data_sync[SYNC_STAGES-1];
    assign w_fall   = r_clk_hist & ~w_clk_s;

`ifdef PS2_WATCHDOG_EN
    localparam int                c_wd_w     = $clog2(TIMEOUT_CYCLES);
    localparam logic [c_wd_w-1:0] c_wd_limit = c_wd_w'(TIMEOUT_CYCLES - 1);

    logic [c_wd_w-1:0] r_wdog;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wdog <= '0;
        end else if (w_fall || (r_state == c_st_idle)) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    assign w_wd_expired = (r_state != c_st_idle) && !w_fall && (r_wdog == c_wd_limit);
`else
    assign w_wd_expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_frame_end = 1'b0;
        case (r_state)
            c_st_idle:   if (w_fall && !w_data_s) w_state_nxt = c_st_data;
            c_st_data:   if (w_fall && (r_bit_cnt == 3'd7)) w_state_nxt = c_st_parity;
            c_st_parity: if (w_fall) w_state_nxt = c_st_stop;
            c_st_stop: begin
                if (w_fall) begin
                    w_state_nxt = c_st_idle;
                    w_frame_end = 1'b1;
                end
            end
            default:     w_state_nxt = c_st_idle;
        endcase
        if (w_wd_expired) begin
            w_state_nxt = c_st_idle;
            w_frame_end = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_parity  <= 1'b0;
        end else if (w_fall) begin
            case (r_state)
                c_st_idle:   r_bit_cnt <= '0;
                c_st_data: begin
                    r_shift   <= {w_data_s, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                c_st_parity: r_parity <= w_data_s;
                default:     ;
            endcase
        end
    end

    // Two stages between frame end and the strobes: frame check, then decode.
    // A watchdog abort enters with stop = 0 so it fails the check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chk_vld  <= 1'b0;
            r_chk_stop <= 1'b0;
            r_dec_vld  <= 1'b0;
            r_dec_ok   <= 1'b0;
            r_dec_byte <= '0;
        end else begin
            r_chk_vld  <= w_frame_end | w_wd_expired;
            r_chk_stop <= w_frame_end & w_data_s;
            r_dec_vld  <= r_chk_vld;
            r_dec_ok   <= r_chk_stop & (^{r_shift, r_parity});
            r_dec_byte <= r_shift;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scan_code   <= '0;
            r_scan_valid  <= 1'b0;
            r_is_break    <= 1'b0;
            r_is_extended <= 1'b0;
            r_frame_err   <= 1'b0;
            r_key_held    <= 1'b0;
            r_flap        <= 1'b0;
            r_ext_pending <= 1'b0;
            r_brk_pending <= 1'b0;
        end else begin
            r_scan_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            r_flap       <= 1'b0;
            if (r_dec_vld) begin
                if (!r_dec_ok) begin
                    r_frame_err   <= 1'b1;
                    r_ext_pending <= 1'b0;
                    r_brk_pending <= 1'b0;
                end else if (r_dec_byte == c_pfx_ext) begin
                    r_ext_pending <= 1'b1;
                end else if (r_dec_byte == c_pfx_brk) begin
                    r_brk_pending <= 1'b1;
                end else begin
                    r_scan_code   <= r_dec_byte;
                    r_is_break    <= r_brk_pending;
                    r_is_extended <= r_ext_pending;
                    r_scan_valid  <= 1'b1;
                    r_ext_pending <= 1'b0;
                    r_brk_pending <= 1'b0;
                    // Typematic repeats of a held flap key must not re-strike.
                    if (!r_ext_pending && (r_dec_byte == FLAP_CODE)) begin
                        if (r_brk_pending) begin
                            r_key_held <= 1'b0;
                        end else if (!r_key_held) begin
                            r_key_held <= 1'b1;
                            r_flap     <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign scan_code   = r_scan_code;
    assign scan_valid  = r_scan_valid;
    assign is_break    = r_is_break;
    assign is_extended = r_is_extended;
    assign frame_err   = r_frame_err;
    assign key_held    = r_key_held;
    assign flap        = r_flap;

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_ps2_key_rx
// Brief    : Scoreboard bench for ps2_key_rx: directed and random PS/2 frames
//            against a key-event model. Watchdog case runs with PS2_WATCHDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_key_rx;

    localparam int         c_sync    = 2;
    localparam int         c_tout    = 1000;
    localparam logic [7:0] c_flap    = 8'h29;
    localparam int         c_half_ns = 200;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       clk_ps2  = 1'b1;
    logic       data_ps2 = 1'b1;
    logic [7:0] scan_code;
    logic       scan_valid;
    logic       is_break;
    logic       is_extended;
    logic       frame_err;
    logic       key_held;
    logic       flap;

    ps2_key_rx #(
        .SYNC_STAGES   (c_sync),
        .TIMEOUT_CYCLES(c_tout),
        .FLAP_CODE     (c_flap)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_ps2    (clk_ps2),
        .data_ps2   (data_ps2),
        .scan_code  (scan_code),
        .scan_valid (scan_valid),
        .is_break   (is_break),
        .is_extended(is_extended),
        .frame_err  (frame_err),
        .key_held   (key_held),
        .flap       (flap)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected vector: {scan_valid, frame_err, code, brk, ext, flap, held}
    typedef struct {
        logic [13:0] v;
        int          lo;
        int          hi;
    } exp_t;

    exp_t q[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    bit         m_ext, m_brk, m_held, m_brk_o, m_ext_o;
    logic [7:0] m_code;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] lo, input logic [63:0] hi);
        n_tot++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h..0x%0h", name, act, lo, hi);
    endtask

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_held = 0; m_brk_o = 0; m_ext_o = 0; m_code = 8'h00;
    endtask

    task automatic model_err(input int lo, input int hi);
        exp_t e;
        e.v  = {1'b0, 1'b1, m_code, m_brk_o, m_ext_o, 1'b0, m_held};
        e.lo = lo;
        e.hi = hi;
        q.push_back(e);
        m_ext = 0;
        m_brk = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, input bit ok, input int at);
        exp_t e;
        bit   f;
        if (!ok) begin
            model_err(at, at);
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else begin
            f = 0;
            if (!m_ext && b == c_flap) begin
                if (m_brk) m_held = 0;
                else if (!m_held) begin
                    m_held = 1;
                    f = 1;
                end
            end
            e.v  = {1'b1, 1'b0, b, m_brk, m_ext, f, m_held};
            e.lo = at;
            e.hi = at;
            q.push_back(e);
            m_code = b; m_brk_o = m_brk; m_ext_o = m_ext;
            m_ext = 0; m_brk = 0;
        end
    endtask

    // Drives the first nbits of a frame; the model is updated at the stop edge.
    task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                        input int nbits, output int last_fall);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        last_fall = cyc;
        for (int i = 0; i < nbits; i++) begin
            data_ps2 = f[i];
            #(c_half_ns);
            clk_ps2   = 1'b0;
            last_fall = cyc;
            if (i == 10) model_byte(b, !bad_par && !bad_stop, cyc + c_sync + 3);
            #(c_half_ns);
            clk_ps2 = 1'b1;
        end
        data_ps2 = 1'b1;
        #(c_half_ns * 3);
    endtask

    task automatic frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
        int lf;
        send(b, bad_par, bad_stop, 11, lf);
    endtask

    function automatic logic [13:0] outs();
        return {scan_valid, frame_err, scan_code, is_break, is_extended, flap, key_held};
    endfunction

    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n) begin
            if (flap) check("flap_needs_valid", scan_valid, 1, 1);
            if (scan_valid || frame_err) begin
                check("strobe_exclusive", scan_valid & frame_err, 0, 0);
                if (q.size() == 0) begin
                    check("unexpected_strobe", outs(), 0, 0);
                end else begin
                    mon_e = q.pop_front();
                    check("event", outs(), mon_e.v, mon_e.v);
                    check("latency", cyc, mon_e.lo, mon_e.hi);
                end
            end
        end
    end

    initial begin
        int         lf;
        int         r;
        logic [7:0] b;
        model_reset();
        #53;
        check("reset_outputs", outs(), 0, 0);
        rst_n = 1'b1;
        #(c_half_ns * 2);

        // First flap press, typematic repeats, release via F0
        frame(8'h29, 0, 0);
        frame(8'h29, 0, 0);
        frame(8'h29, 0, 0);
        frame(8'hF0, 0, 0);
        frame(8'h29, 0, 0);

        // Lone F0, then extended break
        frame(8'hF0, 0, 0);
        frame(8'hE0, 0, 0);
        frame(8'hF0, 0, 0);
        frame(8'h75, 0, 0);

        // Parity error then stop-bit error
        frame(8'h1C, 1, 0);
        frame(8'h1C, 0, 1);

`ifdef PS2_WATCHDOG_EN
        send(8'h1C, 0, 0, 5, lf);
        model_err(lf + c_tout, lf + c_tout + c_sync + 8);
        #(c_tout * 10 + 500);
        frame(8'h29, 0, 0);
`endif

        // Reset mid-frame after an E0 prefix
        frame(8'hE0, 0, 0);
        send(8'h29, 0, 0, 5, lf);
        rst_n = 1'b0;
        #50;
        check("reset_mid_frame", outs(), 0, 0);
        model_reset();
        rst_n = 1'b1;
        #(c_half_ns * 2);
        frame(8'h29, 0, 0);

        // Random traffic biased towards prefixes and the flap key
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 9);
            case (r)
                0, 1, 2: b = 8'h29;
                3:       b = 8'hE0;
                4:       b = 8'hF0;
                5:       b = 8'h75;
                default: b = 8'($urandom);
            endcase
            frame(b, $urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0);
            #(c_half_ns * $urandom_range(0, 4));
        end

        for (int i = 0; i < 2000 && q.size() != 0; i++) @(posedge clk);
        check("scoreboard_drained", q.size(), 0, 0);
        #20;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

`default_nettype wire
